// File: rtl/serial_pkg.sv
// serial_pkg: state encoding and timing helpers shared by the serial transmitter and receiver
package serial_pkg;
  typedef enum logic [1:0] {Ready, Transmit, Receive} t_serial_state;
  function automatic int timeout_limit(input int cycles, input int main_hz, input int serial_hz);
    return int'(longint'(cycles) * longint'(main_hz) / longint'(serial_hz));
  endfunction
endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-stage synchroniser with a detector for transitions into EDGE_LEVEL
module sync_edge #(
  parameter int STAGES     = 2,
  parameter bit INACTIVE   = 1'b1,
  parameter bit EDGE_LEVEL = 1'b0
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_async,
  output logic out_sync,
  output logic out_edge
);
  logic [STAGES-1:0] sync_q;
  logic prev_q;
  // shift the asynchronous input through the chain and remember the last synchronised value
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      sync_q <= {STAGES{INACTIVE}};
      prev_q <= INACTIVE;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], in_async};
      prev_q <= sync_q[STAGES-1];
    end
  end
  assign out_sync = sync_q[STAGES-1];
  assign out_edge = (out_sync == EDGE_LEVEL) && (prev_q != EDGE_LEVEL);
endmodule

// File: rtl/deserial.sv
// deserial: oversampling serial-to-parallel receiver assembling BITS-bit words
module deserial
  import serial_pkg::*;
#(
  parameter int MAIN_CLK_HZ           = 50_000_000,
  parameter int SERIAL_CLK_HZ         = 10_000,
  parameter bit SERIAL_CLK_INACTIVE   = 1'b1,
  parameter bit SERIAL_DATA_INACTIVE  = 1'b1,
  parameter int BITS                  = 8,
  parameter bit LOWBIT_FIRST          = 1'b1,
  parameter int SYNC_STAGES           = 2,
  parameter int TIMEOUT_SERIAL_CYCLES = 2
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_serial_clk,
  input  logic            in_serial,
  input  logic            in_enable,
  output logic [BITS-1:0] out_parallel,
  output logic            out_word_valid,
  output logic            out_busy,
  output logic            out_ready
);
  localparam int LIMIT = timeout_limit(TIMEOUT_SERIAL_CYCLES, MAIN_CLK_HZ, SERIAL_CLK_HZ);
  localparam int CTR_W = $clog2(BITS) + 1;
  localparam int TMO_W = $clog2(LIMIT + 1);
  t_serial_state state_q, state_d;
  logic [CTR_W-1:0] bit_ctr;
  logic [TMO_W-1:0] tmo;
  logic [BITS-1:0] shreg;
  logic done, sclk_edge, sdata, rx, take, last, expire;
  sync_edge #(.STAGES(SYNC_STAGES), .INACTIVE(SERIAL_CLK_INACTIVE), .EDGE_LEVEL(!SERIAL_CLK_INACTIVE)) u_clk (
    .in_clk(in_clk), .in_rst(in_rst), .in_async(in_serial_clk), .out_sync(), .out_edge(sclk_edge)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .INACTIVE(SERIAL_DATA_INACTIVE), .EDGE_LEVEL(!SERIAL_DATA_INACTIVE)) u_data (
    .in_clk(in_clk), .in_rst(in_rst), .in_async(in_serial), .out_sync(sdata), .out_edge()
  );
  // next state and per-cycle decisions; disable beats a coincident edge
  always_comb begin
    state_d = in_enable ? Receive : Ready;
    rx      = (state_q == Receive) && in_enable;
    take    = rx && sclk_edge;
    last    = bit_ctr == CTR_W'(BITS - 1);
    expire  = tmo == TMO_W'(LIMIT);
  end
  // state register, shifter, bit/timeout counters and delayed word output
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q        <= Ready;
      bit_ctr        <= '0;
      tmo            <= '0;
      shreg          <= '0;
      done           <= 1'b0;
      out_parallel   <= '0;
      out_word_valid <= 1'b0;
    end else begin
      state_q        <= state_d;
      done           <= take && last;
      out_word_valid <= done;
      out_parallel   <= done ? shreg : out_parallel;
      shreg          <= !take ? shreg : LOWBIT_FIRST ? {sdata, shreg[BITS-1:1]} : {shreg[BITS-2:0], sdata};
      bit_ctr        <= !rx ? '0 : take ? (last ? '0 : bit_ctr + CTR_W'(1)) : expire ? '0 : bit_ctr;
      tmo            <= (rx && bit_ctr != '0 && !take && !expire) ? tmo + TMO_W'(1) : '0;
    end
  end
  assign out_busy  = (state_q == Receive) && (bit_ctr != '0);
  assign out_ready = state_q == Ready;
endmodule
